// File: rtl/biu_rom_port_arbiter_if.sv
// Bus bundle between the loader/core requesters, the port-B arbiter and the code RAM port B.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface biu_rom_port_arbiter_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 8
);
    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_ack;
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_ack;
    logic [DATA_W-1:0] rd_data;
    logic              load_lock;
    logic              busy;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport slave (
        input  ld_req, ld_we, ld_addr, ld_wdata, cpu_req, cpu_addr, load_lock, ram_dout,
        output ld_ack, cpu_ack, rd_data, busy, ram_addr, ram_we, ram_din
    );

    modport master (
        output ld_req, ld_we, ld_addr, ld_wdata, cpu_req, cpu_addr, load_lock, ram_dout,
        input  ld_ack, cpu_ack, rd_data, busy, ram_addr, ram_we, ram_din
    );
endinterface

// File: rtl/biu_rom_port_arbiter.sv
// Round-robin arbiter sharing code RAM port B between the serial loader (rd/wr)
// and the core MOVC read path; every access is IDLE -> ACCESS -> RESP, three clocks.
module biu_rom_port_arbiter #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 8
) (
    input logic                     CORE_CLK,
    input logic                     RST_n,
    biu_rom_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    // Set when the loader won last, so the core takes the next tie; 0 favours the loader.
    logic              favour_cpu_q, favour_cpu_d;
    logic              owner_cpu_q, owner_cpu_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic              ram_we_q, ram_we_d;
    logic              ld_ack_q, ld_ack_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              busy_q, busy_d;
    logic              cpu_elig;
    logic              grant_cpu;

    // State and registered outputs; reset drops ram_we immediately and abandons any access.
    always_ff @(posedge CORE_CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q      <= IDLE;
            favour_cpu_q <= 1'b0;
            owner_cpu_q  <= 1'b0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            ram_we_q     <= 1'b0;
            ld_ack_q     <= 1'b0;
            cpu_ack_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            favour_cpu_q <= favour_cpu_d;
            owner_cpu_q  <= owner_cpu_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            ram_we_q     <= ram_we_d;
            ld_ack_q     <= ld_ack_d;
            cpu_ack_q    <= cpu_ack_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state, arbitration and output decode.
    always_comb begin
        state_d      = state_q;
        favour_cpu_d = favour_cpu_q;
        owner_cpu_d  = owner_cpu_q;
        ram_addr_d   = ram_addr_q;
        ram_din_d    = ram_din_q;
        ram_we_d     = 1'b0;
        ld_ack_d     = 1'b0;
        cpu_ack_d    = 1'b0;
        cpu_elig     = bus.cpu_req && !bus.load_lock;
        grant_cpu    = cpu_elig && (!bus.ld_req || favour_cpu_q);

        case (state_q)
            IDLE: begin
                if (bus.ld_req || cpu_elig) begin
                    state_d      = ACCESS;
                    owner_cpu_d  = grant_cpu;
                    favour_cpu_d = !grant_cpu;
                    if (grant_cpu) begin
                        ram_addr_d = bus.cpu_addr;
                        ram_din_d  = '0;
                    end else begin
                        ram_addr_d = bus.ld_addr;
                        ram_din_d  = bus.ld_wdata;
                        ram_we_d   = bus.ld_we;
                    end
                end
            end
            ACCESS: begin
                state_d   = RESP;
                ld_ack_d  = !owner_cpu_q;
                cpu_ack_d = owner_cpu_q;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_din  = ram_din_q;
    assign bus.ram_we   = ram_we_q;
    assign bus.ld_ack   = ld_ack_q;
    assign bus.cpu_ack  = cpu_ack_q;
    assign bus.busy     = busy_q;
    // RAM output is registered, so read data is only meaningful in the response cycle.
    assign bus.rd_data  = (state_q == RESP) ? bus.ram_dout : '0;

endmodule

// File: tb/tb_biu_rom_port_arbiter.sv
// Directed bench for biu_rom_port_arbiter with a behavioural 4K x 8 registered-read RAM.
module tb_biu_rom_port_arbiter;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 8;

    logic CORE_CLK = 1'b0;
    logic RST_n    = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 CORE_CLK = ~CORE_CLK;

    biu_rom_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    biu_rom_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CORE_CLK (CORE_CLK),
        .RST_n    (RST_n),
        .bus      (bus_if)
    );

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always @(posedge CORE_CLK) begin
        if (bus_if.ram_we) mem[bus_if.ram_addr] <= bus_if.ram_din;
        bus_if.ram_dout <= mem[bus_if.ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CORE_CLK);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        mem[12'hFFF]       = 8'h3C;
        bus_if.ld_req      = 1'b0;
        bus_if.ld_we       = 1'b0;
        bus_if.ld_addr     = '0;
        bus_if.ld_wdata    = '0;
        bus_if.cpu_req     = 1'b0;
        bus_if.cpu_addr    = '0;
        bus_if.load_lock   = 1'b0;
        bus_if.ram_dout    = '0;

        // Reset state
        #2 RST_n = 1'b0;
        #1;
        chk("rst ld_ack",   32'(bus_if.ld_ack),   32'd0);
        chk("rst cpu_ack",  32'(bus_if.cpu_ack),  32'd0);
        chk("rst busy",     32'(bus_if.busy),     32'd0);
        chk("rst ram_we",   32'(bus_if.ram_we),   32'd0);
        chk("rst ram_addr", 32'(bus_if.ram_addr), 32'd0);
        chk("rst rd_data",  32'(bus_if.rd_data),  32'd0);
        tick();
        tick();
        RST_n = 1'b1;
        tick();

        // 1. Loader write then read-back
        bus_if.ld_req = 1'b1; bus_if.ld_we = 1'b1;
        bus_if.ld_addr = 12'h010; bus_if.ld_wdata = 8'hA5;
        tick();
        chk("t1 wr ram_we",   32'(bus_if.ram_we),   32'd1);
        chk("t1 wr ram_addr", 32'(bus_if.ram_addr), 32'h010);
        chk("t1 wr ram_din",  32'(bus_if.ram_din),  32'hA5);
        chk("t1 wr ack early",32'(bus_if.ld_ack),   32'd0);
        chk("t1 wr busy",     32'(bus_if.busy),     32'd1);
        tick();
        chk("t1 wr ld_ack",   32'(bus_if.ld_ack),   32'd1);
        chk("t1 wr we off",   32'(bus_if.ram_we),   32'd0);
        chk("t1 wr addr hold",32'(bus_if.ram_addr), 32'h010);
        bus_if.ld_we = 1'b0;
        tick();
        chk("t1 idle busy",   32'(bus_if.busy),     32'd0);
        chk("t1 idle ack",    32'(bus_if.ld_ack),   32'd0);
        tick();
        chk("t1 rd ram_we",   32'(bus_if.ram_we),   32'd0);
        tick();
        chk("t1 rd ld_ack",   32'(bus_if.ld_ack),   32'd1);
        chk("t1 rd rd_data",  32'(bus_if.rd_data),  32'hA5);
        bus_if.ld_req = 1'b0;
        tick();

        // 2. Core read of top address
        bus_if.cpu_req = 1'b1; bus_if.cpu_addr = 12'hFFF;
        tick();
        chk("t2 ram_we",      32'(bus_if.ram_we),   32'd0);
        chk("t2 ram_addr",    32'(bus_if.ram_addr), 32'hFFF);
        tick();
        chk("t2 cpu_ack",     32'(bus_if.cpu_ack),  32'd1);
        chk("t2 ld_ack",      32'(bus_if.ld_ack),   32'd0);
        chk("t2 rd_data",     32'(bus_if.rd_data),  32'h3C);
        chk("t2 ram_we resp", 32'(bus_if.ram_we),   32'd0);
        bus_if.cpu_req = 1'b0;
        tick();
        chk("t2 ack drop",    32'(bus_if.cpu_ack),  32'd0);

        // 3. Both held from reset: loader, core, loader, core
        RST_n = 1'b0;
        tick();
        RST_n = 1'b1;
        bus_if.ld_req = 1'b1; bus_if.ld_we = 1'b0; bus_if.ld_addr = 12'h020;
        bus_if.cpu_req = 1'b1; bus_if.cpu_addr = 12'h030;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("t3 ld_ack c%0d", k),  32'(bus_if.ld_ack),  32'(k % 6 == 2));
            chk($sformatf("t3 cpu_ack c%0d", k), 32'(bus_if.cpu_ack), 32'(k % 6 == 5));
            chk($sformatf("t3 busy c%0d", k),    32'(bus_if.busy),    32'(k % 3 != 0));
            if (k % 3 == 2)
                chk($sformatf("t3 addr c%0d", k), 32'(bus_if.ram_addr),
                    (k % 6 == 2) ? 32'h020 : 32'h030);
        end

        // 4. load_lock: only the loader is served; release grants the core
        bus_if.load_lock = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk($sformatf("t4 ld_ack c%0d", k),  32'(bus_if.ld_ack),  32'(k % 3 == 2));
            chk($sformatf("t4 cpu_ack c%0d", k), 32'(bus_if.cpu_ack), 32'd0);
        end
        bus_if.load_lock = 1'b0;
        tick();
        chk("t4 unlock addr",   32'(bus_if.ram_addr), 32'h030);
        tick();
        chk("t4 unlock cpu_ack",32'(bus_if.cpu_ack),  32'd1);
        chk("t4 unlock ld_ack", 32'(bus_if.ld_ack),   32'd0);
        bus_if.ld_req = 1'b0; bus_if.cpu_req = 1'b0;
        tick();

        // 5. Reset during the ACCESS cycle of a write
        bus_if.ld_req = 1'b1; bus_if.ld_we = 1'b1;
        bus_if.ld_addr = 12'h040; bus_if.ld_wdata = 8'h5A;
        tick();
        chk("t5 ram_we pre",    32'(bus_if.ram_we), 32'd1);
        #2 RST_n = 1'b0;
        #1;
        chk("t5 async ram_we",  32'(bus_if.ram_we), 32'd0);
        chk("t5 async busy",    32'(bus_if.busy),   32'd0);
        bus_if.ld_req = 1'b0;
        tick();
        chk("t5 no ack",        32'(bus_if.ld_ack), 32'd0);
        chk("t5 mem untouched", 32'(mem[12'h040]),  32'h00);
        RST_n = 1'b1;
        tick();
        chk("t5 idle busy",     32'(bus_if.busy),   32'd0);
        bus_if.ld_req = 1'b1; bus_if.ld_wdata = 8'h77;
        tick();
        tick();
        chk("t5 fresh ld_ack",  32'(bus_if.ld_ack), 32'd1);
        chk("t5 fresh mem",     32'(mem[12'h040]),  32'h77);
        bus_if.ld_req = 1'b0; bus_if.ld_we = 1'b0;
        tick();

        // 6. Core pulse while busy is ignored; core drop after grant still acks
        bus_if.ld_req = 1'b1; bus_if.ld_addr = 12'h010;
        tick();
        bus_if.cpu_req = 1'b1; bus_if.cpu_addr = 12'hFFF;
        tick();
        bus_if.cpu_req = 1'b0;
        chk("t6 ld_ack",        32'(bus_if.ld_ack),  32'd1);
        chk("t6 ld rd_data",    32'(bus_if.rd_data), 32'hA5);
        bus_if.ld_req = 1'b0;
        tick();
        chk("t6 idle cpu_ack",  32'(bus_if.cpu_ack), 32'd0);
        chk("t6 idle rd_data",  32'(bus_if.rd_data), 32'd0);
        tick();
        chk("t6 pulse ignored", 32'(bus_if.busy),    32'd0);
        bus_if.cpu_req = 1'b1;
        tick();
        bus_if.cpu_req = 1'b0;
        chk("t6 cpu busy",      32'(bus_if.busy),    32'd1);
        tick();
        chk("t6 late cpu_ack",  32'(bus_if.cpu_ack), 32'd1);
        chk("t6 late rd_data",  32'(bus_if.rd_data), 32'h3C);
        tick();
        chk("t6 back idle",     32'(bus_if.busy),    32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
